// File: rtl/fractal_sync_pkg.sv
// -----------------------------------------------------------------------------
// fractal_sync_pkg
//   Shared definitions for the fractal sync tx response scheduler.
//   - TX_IDLE_S / TX_HOLD_S : raw state encodings, kept as plain constants so
//                             older code that compares against bit values
//                             still works.
//   - tx_state_e            : FSM state type for the output stage.
//   - rr_wrap_inc           : modular increment used for round-robin pointers.
// -----------------------------------------------------------------------------
package fractal_sync_pkg;

  localparam logic [0:0] TX_IDLE_S = 1'b0;
  localparam logic [0:0] TX_HOLD_S = 1'b1;

  typedef enum logic [0:0] {
    TX_IDLE = TX_IDLE_S,  // output register empty, valid_o = 0
    TX_HOLD = TX_HOLD_S   // output register holds a response, valid_o = 1
  } tx_state_e;

  // (idx + 1) mod n, for idx in [0, n-1]
  function automatic int unsigned rr_wrap_inc(input int unsigned idx,
                                              input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// -----------------------------------------------------------------------------
// fractal_sync_rr_arb
//   Round-robin arbiter. Grants the first requesting port at or after the
//   internal priority pointer, wrapping from N_PORTS-1 back to 0. When
//   update_i is high the pointer moves to one past the current grant.
//
// Ports
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset (pointer returns to port 0)
//   req_i      : per-port request
//   update_i   : commit the current grant and advance the pointer
//   gnt_o      : one-hot grant (all zero when no request)
//   gnt_idx_o  : index of the granted port (0 when no request)
// -----------------------------------------------------------------------------
module fractal_sync_rr_arb
  import fractal_sync_pkg::*;
#(
  parameter  int unsigned N_PORTS = 2,
  localparam int unsigned IDX_W   = $clog2(N_PORTS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_PORTS-1:0] req_i,
  input  logic               update_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_found;
  logic             any_req;

  assign any_req = |req_i;

  // Two-pass priority search without dynamic indexing: hi_* finds the lowest
  // requester at or above the pointer, lo_* the lowest requester overall.
  // Scanning downward leaves the lowest match in the variable. If nothing
  // sits at or above the pointer, the search wraps, which is lo_idx.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int p = N_PORTS - 1; p >= 0; p--) begin
      if (req_i[p]) begin
        lo_idx = IDX_W'(p);
        if (IDX_W'(p) >= rr_ptr_reg) begin
          hi_idx   = IDX_W'(p);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign gnt_idx_o = hi_found ? hi_idx : lo_idx;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_gnt
    assign gnt_o[gi] = any_req && (gnt_idx_o == IDX_W'(gi));
  end

  assign rr_ptr_next = IDX_W'(rr_wrap_inc(32'(gnt_idx_o), N_PORTS));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_reg <= '0;
    end else if (update_i && any_req) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/fractal_sync_tx_sched.sv
// -----------------------------------------------------------------------------
// fractal_sync_tx_sched
//   Arbitrates N_PORTS tx response FIFOs onto one registered link. A response
//   is popped from the round-robin winner and loaded into the output register
//   whenever the register is empty or is being accepted this cycle, giving
//   one response per cycle under continuous ready. Also tracks FIFO overflow
//   with per-port sticky flags and a saturating event counter.
//
// Ports
//   clk_i            : clock
//   rst_ni           : asynchronous active-low reset
//   empty_i          : per-port FIFO empty
//   rsp_i            : per-port FIFO head (valid while empty_i bit is 0)
//   pop_o            : per-port FIFO pop (one-hot or zero)
//   error_overflow_i : per-port FIFO overflow pulse
//   rsp_o            : registered response to the link
//   valid_o          : rsp_o holds a response
//   ready_i          : link accepts rsp_o this cycle
//   grant_idx_o      : source port of rsp_o
//   clear_error_i    : clears sticky flags and counter
//   error_sticky_o   : per-port sticky overflow flags
//   error_cnt_o      : saturating count of cycles with any overflow
// -----------------------------------------------------------------------------
module fractal_sync_tx_sched
  import fractal_sync_pkg::*;
#(
  parameter type         fsync_rsp_t = logic,
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned ERR_CNT_W   = 8,
  localparam int unsigned IDX_W      = $clog2(N_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_PORTS-1:0]   empty_i,
  input  fsync_rsp_t           rsp_i [N_PORTS],
  output logic [N_PORTS-1:0]   pop_o,
  input  logic [N_PORTS-1:0]   error_overflow_i,
  output fsync_rsp_t           rsp_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [IDX_W-1:0]     grant_idx_o,
  input  logic                 clear_error_i,
  output logic [N_PORTS-1:0]   error_sticky_o,
  output logic [ERR_CNT_W-1:0] error_cnt_o
);

  if (N_PORTS < 2) begin : g_bad_ports
    $fatal(1, "fractal_sync_tx_sched: N_PORTS must be >= 2");
  end
  if (ERR_CNT_W < 1) begin : g_bad_cnt_w
    $fatal(1, "fractal_sync_tx_sched: ERR_CNT_W must be >= 1");
  end

  tx_state_e            state_reg;
  tx_state_e            state_next;
  fsync_rsp_t           rsp_reg;
  logic [IDX_W-1:0]     grant_idx_reg;
  logic [N_PORTS-1:0]   sticky_reg;
  logic [N_PORTS-1:0]   sticky_next;
  logic [ERR_CNT_W-1:0] cnt_reg;
  logic [ERR_CNT_W-1:0] cnt_next;

  logic [N_PORTS-1:0]   req;
  logic [N_PORTS-1:0]   gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 load;
  logic                 ovf_any;

  assign req = ~empty_i;

  // The register can take a new response when it is empty or its current
  // content leaves this cycle. ready_i only matters in HOLD. rst_ni gates
  // the pop so nothing is drained from a FIFO while reset is held.
  assign load = rst_ni && (|req) && ((state_reg == TX_IDLE) || ready_i);

  fractal_sync_rr_arb #(
    .N_PORTS (N_PORTS)
  ) u_rr_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req),
    .update_i  (load),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign pop_o = load ? gnt : '0;

  // ---------------------------------------------------------------------------
  // Output stage FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      TX_IDLE: if (load) state_next = TX_HOLD;
      TX_HOLD: if (ready_i && !load) state_next = TX_IDLE;
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= TX_IDLE;
      rsp_reg       <= '0;
      grant_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        rsp_reg       <= rsp_i[gnt_idx];
        grant_idx_reg <= gnt_idx;
      end
    end
  end

  assign rsp_o       = rsp_reg;
  assign grant_idx_o = grant_idx_reg;
  assign valid_o     = (state_reg == TX_HOLD);

  // ---------------------------------------------------------------------------
  // Overflow status. A clear and a same-cycle overflow resolve in favour of
  // the new event so it is never lost.
  // ---------------------------------------------------------------------------
  assign ovf_any = |error_overflow_i;

  always_comb begin
    sticky_next = (clear_error_i ? '0 : sticky_reg) | error_overflow_i;
    cnt_next    = cnt_reg;
    if (clear_error_i) begin
      cnt_next = ovf_any ? ERR_CNT_W'(1) : '0;
    end else if (ovf_any && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      sticky_reg <= sticky_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign error_sticky_o = sticky_reg;
  assign error_cnt_o    = cnt_reg;

endmodule

// File: tb/tb_fractal_sync_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_fractal_sync_tx_sched
//   Scoreboard bench. The FIFOs are modelled as queues; the expected arbiter
//   decision is derived from the round-robin rule and pushed to a scoreboard,
//   a monitor pops and compares on every link transfer.
// -----------------------------------------------------------------------------
module tb_fractal_sync_tx_sched;

  localparam int N   = 2;
  localparam int CW  = 2;
  localparam int MAX = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  empty_i;
  logic [15:0] rsp_i [2];
  logic [1:0]  pop_o;
  logic [1:0]  error_overflow_i;
  logic [15:0] rsp_o;
  logic        valid_o;
  logic        ready_i;
  logic        grant_idx_o;
  logic        clear_error_i;
  logic [1:0]  error_sticky_o;
  logic [CW-1:0] error_cnt_o;

  fractal_sync_tx_sched #(
    .fsync_rsp_t (logic [15:0]),
    .N_PORTS     (N),
    .ERR_CNT_W   (CW)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .empty_i          (empty_i),
    .rsp_i            (rsp_i),
    .pop_o            (pop_o),
    .error_overflow_i (error_overflow_i),
    .rsp_o            (rsp_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .grant_idx_o      (grant_idx_o),
    .clear_error_i    (clear_error_i),
    .error_sticky_o   (error_sticky_o),
    .error_cnt_o      (error_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // FIFO contents, scoreboard and reference state
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [16:0] sb[$];
  int          seq = 0;
  int          delivered = 0;
  int          m_ptr = 0;
  bit          m_valid = 0;
  logic [1:0]  m_sticky = 0;
  int          m_cnt = 0;

  // bench controls
  logic [1:0] tb_mask = 0;
  logic       tb_ready = 0;
  logic [1:0] tb_ovf = 0;
  logic       tb_clr = 0;
  logic [1:0] ne;

  // last sampled DUT values
  logic [1:0]  last_pop;
  logic        last_valid;
  logic [15:0] last_rsp;
  logic        last_gidx;
  logic [1:0]  last_sticky;
  logic [CW-1:0] last_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [15:0] q_head(input int p);
    return (p == 0) ? q0[0] : q1[0];
  endfunction

  function automatic logic [15:0] q_pop(input int p);
    return (p == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  task automatic q_push(input int p);
    logic [15:0] d;
    d = {p[0], seq[14:0]};
    seq++;
    if (p == 0) q0.push_back(d); else q1.push_back(d);
  endtask

  task automatic apply_inputs();
    for (int p = 0; p < N; p++) begin
      ne[p]      = (q_size(p) != 0) && !tb_mask[p];
      rsp_i[p]   = ne[p] ? q_head(p) : 16'($urandom);
    end
    empty_i          = ~ne;
    ready_i          = tb_ready;
    error_overflow_i = tb_ovf;
    clear_error_i    = tb_clr;
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_valid  = 0;
    m_sticky = 0;
    m_cnt    = 0;
    sb.delete();
  endtask

  // One clock cycle: drive, check at negedge, advance the reference model.
  task automatic cycle();
    logic [1:0] exp_pop;
    int g;
    apply_inputs();
    @(negedge clk_i);
    last_pop    = pop_o;
    last_valid  = valid_o;
    last_rsp    = rsp_o;
    last_gidx   = grant_idx_o;
    last_sticky = error_sticky_o;
    last_cnt    = error_cnt_o;
    chk("valid", 32'(valid_o), 32'(m_valid));
    chk("err_sticky", 32'(error_sticky_o), 32'(m_sticky));
    chk("err_cnt", 32'(error_cnt_o), 32'(m_cnt));
    chk("pop_on_empty", 32'(pop_o & empty_i), 0);
    chk("pop_onehot", 32'($onehot0(pop_o)), 1);
    exp_pop = 0;
    if ((!m_valid || tb_ready) && (ne != 0)) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (g < 0 && ne[p]) g = p;
      end
      exp_pop[g] = 1'b1;
      sb.push_back({g[0], q_pop(g)});
      m_ptr   = (g + 1) % N;
      m_valid = 1;
    end else if (m_valid && tb_ready) begin
      m_valid = 0;
    end
    chk("pop", 32'(pop_o), 32'(exp_pop));
    if (tb_clr) begin
      m_sticky = tb_ovf;
      m_cnt    = (tb_ovf != 0) ? 1 : 0;
    end else begin
      m_sticky = m_sticky | tb_ovf;
      if (tb_ovf != 0 && m_cnt < MAX) m_cnt++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    bit busy;
    tb_mask = 0; tb_ready = 1; tb_ovf = 0; tb_clr = 0;
    for (int i = 0; i < 50; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && !m_valid) break;
      cycle();
    end
    busy = (q0.size() != 0) || (q1.size() != 0) || m_valid;
    chk("drain_timeout", 32'(busy), 0);
  endtask

  // Monitor: every accepted response must match the scoreboard head.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_rsp: got %0h with empty scoreboard", rsp_o);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("rsp_data", 32'(rsp_o), 32'(e[15:0]));
        chk("rsp_port", 32'(grant_idx_o), 32'(e[16]));
        delivered++;
        $display("txn port=%0d data=%h", grant_idx_o, rsp_o);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int c0;
    rst_ni = 1'b0;
    tb_ready = 1;
    q_push(0); q_push(1);
    apply_inputs();
    // reset state, with both ports presenting data
    @(negedge clk_i);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_pop", 32'(pop_o), 0);
    chk("rst_rsp", 32'(rsp_o), 0);
    chk("rst_gidx", 32'(grant_idx_o), 0);
    chk("rst_sticky", 32'(error_sticky_o), 0);
    chk("rst_cnt", 32'(error_cnt_o), 0);
    q0.delete(); q1.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    model_reset();

    // alternating grants with both FIFOs holding 3 entries
    repeat (3) begin q_push(0); q_push(1); end
    tb_ready = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("alt_grant", 32'(last_pop), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    drain();

    // port 1 only, stalled link
    q_push(1); q_push(1);
    tb_ready = 0;
    cycle();
    chk("stall_first_pop", 32'(last_pop), 32'h2);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pop", 32'(last_pop), 0);
      chk("stall_valid", 32'(last_valid), 1);
      chk("stall_rsp", 32'(last_rsp), 32'h8000 | 32'(seq - 2));
    end
    tb_ready = 1;
    cycle();
    chk("release_pop", 32'(last_pop), 32'h2);
    drain();

    // counter saturation
    tb_clr = 1; cycle(); tb_clr = 0;
    tb_ovf = 2'b01;
    repeat (5) cycle();
    tb_ovf = 2'b00;
    cycle();
    chk("sat_cnt", 32'(last_cnt), 3);
    chk("sat_sticky", 32'(last_sticky), 32'h1);

    // clear with simultaneous overflow
    tb_clr = 1; tb_ovf = 2'b10; cycle();
    tb_clr = 0; tb_ovf = 2'b00; cycle();
    chk("clr_sticky", 32'(last_sticky), 32'h2);
    chk("clr_cnt", 32'(last_cnt), 1);

    // reset while holding a response from port 1
    drain();
    q_push(0); q_push(1); tb_ready = 1;
    cycle();                 // grants port 0, pointer now at 1
    q0.delete();
    tb_ready = 1;
    cycle();                 // accepts port 0, loads port 1
    tb_ready = 0;
    cycle();
    chk("hold_gidx", 32'(last_gidx), 1);
    chk("hold_valid", 32'(last_valid), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_hold_valid", 32'(valid_o), 0);
    chk("rst_hold_pop", 32'(pop_o), 0);
    model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    q1.delete();
    q_push(0); q_push(1); tb_ready = 1;
    cycle();
    chk("post_rst_grant", 32'(last_pop), 32'h1);
    drain();

    // randomized traffic
    d0 = delivered;
    c0 = seq;
    for (int i = 0; i < 10000; i++) begin
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 2) == 0 && q_size(p) < 8) q_push(p);
      tb_mask  = 2'($urandom_range(0, 3));
      tb_ready = ($urandom_range(0, 3) != 0);
      tb_ovf   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      tb_clr   = ($urandom_range(0, 31) == 0);
      cycle();
    end
    drain();
    @(negedge clk_i);
    chk("no_loss", 32'(delivered - d0), 32'(seq - c0));
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
